// File: rtl/control_sequencer_if.sv
// Control bus between the hard-wired sequencer and the register-bus datapath.
// CTRL_SINGLE_STEP_EN adds the step input used by the single-step hold.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        stop;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step;
`endif

  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
  logic Yin, Zin, ZLowout, ZHighout, Cout, HIin, LOin, HIout, LOout;
  logic conIn, InPortout, outPortin;
  logic [3:0] ALUselect;
  logic run;

  // Sequencer side: reads IR/branch result, drives every strobe
  modport master (
    input  IR, CON_FF, stop,
`ifdef CTRL_SINGLE_STEP_EN
    input  step,
`endif
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
    output Yin, Zin, ZLowout, ZHighout, Cout, HIin, LOin, HIout, LOout,
    output conIn, InPortout, outPortin, ALUselect, run
  );

  // Datapath side
  modport slave (
    output IR, CON_FF, stop,
`ifdef CTRL_SINGLE_STEP_EN
    output step,
`endif
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
    input  Yin, Zin, ZLowout, ZHighout, Cout, HIin, LOin, HIout, LOout,
    input  conIn, InPortout, outPortin, ALUselect, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired T-step control unit: fetch T0-T2, execute T3-T7, with stop/halt.
// Optional CTRL_SINGLE_STEP_EN: after each instruction wait in HOLD until step=1.
module control_sequencer (
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus
);

  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0110;
  localparam logic [3:0] ALU_OR    = 4'b0111;
  localparam logic [3:0] ALU_INCPC = 4'b1001;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_HALT = 5'd26;

`ifdef CTRL_SINGLE_STEP_EN
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_HOLD
  } state_t;
  localparam state_t S_AFTER = S_HOLD;
`else
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;
  localparam state_t S_AFTER = S_T0;
`endif

  typedef struct packed {
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, read, write;
    logic y_in, z_in, zlow_out, zhigh_out, c_out, hi_in, lo_in, hi_out, lo_out;
    logic con_in, in_port_out, out_port_in;
    logic [3:0] alu_sel;
    logic run;
  } ctrl_t;

  state_t     state, state_nxt;
  logic [4:0] opcode_q;
  logic [4:0] op_now;
  logic       done;
  ctrl_t      ctrl;
  logic       unused_ir;

  assign unused_ir = ^bus.IR[26:0];

  // Final control step of each instruction; unlisted opcodes end after fetch
  function automatic state_t last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                        last_step = S_T7;
      OP_BR:                               last_step = S_T6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI:            last_step = S_T5;
      OP_IN, OP_OUT:                       last_step = S_T3;
      default:                             last_step = S_T2;
    endcase
  endfunction

  function automatic logic [3:0] alu_for(input logic [4:0] op);
    case (op)
      OP_SUB:          alu_for = ALU_SUB;
      OP_AND, OP_ANDI: alu_for = ALU_AND;
      OP_OR, OP_ORI:   alu_for = ALU_OR;
      default:         alu_for = ALU_ADD;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  // Opcode captured at the end of T2; execute steps decode only this copy
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               opcode_q <= 5'd0;
    else if (state == S_T2)  opcode_q <= bus.IR[31:27];
  end

  // Next state; in T2 the completion decision must look at IR directly
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    op_now    = (state == S_T2) ? bus.IR[31:27] : opcode_q;
    case (state)
      S_RST: state_nxt = S_T0;
      S_T0:  state_nxt = S_T1;
      S_T1:  state_nxt = S_T2;
      S_T2, S_T3, S_T4, S_T5, S_T6: begin
        if (last_step(op_now) == state) done = 1'b1;
        else                            state_nxt = state_t'(state + 4'd1);
      end
      S_T7:  done = 1'b1;
      S_HALT: state_nxt = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      S_HOLD: if (bus.step) state_nxt = S_T0;
`endif
      default: state_nxt = S_RST;
    endcase
    if (done) state_nxt = (bus.stop || op_now == OP_HALT) ? S_HALT : S_AFTER;
  end

  // Moore decode of state and latched opcode (br T6 also gated by CON_FF)
  always_comb begin
    ctrl     = '0;
    ctrl.run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1;
        ctrl.z_in = 1'b1;   ctrl.alu_sel = ALU_INCPC;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      S_T3: begin
        case (opcode_q)
          OP_LD, OP_LDI, OP_ST: begin
            ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
          end
          OP_BR: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
          end
          OP_IN: begin
            ctrl.in_port_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          OP_OUT: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_port_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (opcode_q)
          OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: begin
            ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = alu_for(opcode_q);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
            ctrl.alu_sel = alu_for(opcode_q);
          end
          OP_BR: begin
            ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode_q)
          OP_LD, OP_ST: begin
            ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
          end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          OP_BR: begin
            ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu_sel = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode_q)
          OP_LD: begin
            ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
          end
          OP_ST: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
          end
          OP_BR: begin
            ctrl.zlow_out = bus.CON_FF; ctrl.pc_in = bus.CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode_q)
          OP_LD: begin
            ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          OP_ST: begin
            ctrl.mdr_out = 1'b1; ctrl.write = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.Gra       = ctrl.gra;
  assign bus.Grb       = ctrl.grb;
  assign bus.Grc       = ctrl.grc;
  assign bus.Rin       = ctrl.r_in;
  assign bus.Rout      = ctrl.r_out;
  assign bus.BAout     = ctrl.ba_out;
  assign bus.PCout     = ctrl.pc_out;
  assign bus.PCin      = ctrl.pc_in;
  assign bus.IncPC     = ctrl.inc_pc;
  assign bus.IRin      = ctrl.ir_in;
  assign bus.MARin     = ctrl.mar_in;
  assign bus.MDRin     = ctrl.mdr_in;
  assign bus.MDRout    = ctrl.mdr_out;
  assign bus.Read      = ctrl.read;
  assign bus.Write     = ctrl.write;
  assign bus.Yin       = ctrl.y_in;
  assign bus.Zin       = ctrl.z_in;
  assign bus.ZLowout   = ctrl.zlow_out;
  assign bus.ZHighout  = ctrl.zhigh_out;
  assign bus.Cout      = ctrl.c_out;
  assign bus.HIin      = ctrl.hi_in;
  assign bus.LOin      = ctrl.lo_in;
  assign bus.HIout     = ctrl.hi_out;
  assign bus.LOout     = ctrl.lo_out;
  assign bus.conIn     = ctrl.con_in;
  assign bus.InPortout = ctrl.in_port_out;
  assign bus.outPortin = ctrl.out_port_in;
  assign bus.ALUselect = ctrl.alu_sel;
  assign bus.run       = ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected strobe sequences built from the
// opcode step lists, compared cycle by cycle under randomized IR/CON_FF/stop.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_q[$];

  control_sequencer_if bus();

  control_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [31:0] M_GRA   = 32'h1 << 31;
  localparam logic [31:0] M_GRB   = 32'h1 << 30;
  localparam logic [31:0] M_GRC   = 32'h1 << 29;
  localparam logic [31:0] M_RIN   = 32'h1 << 28;
  localparam logic [31:0] M_ROUT  = 32'h1 << 27;
  localparam logic [31:0] M_BAOUT = 32'h1 << 26;
  localparam logic [31:0] M_PCOUT = 32'h1 << 25;
  localparam logic [31:0] M_PCIN  = 32'h1 << 24;
  localparam logic [31:0] M_INCPC = 32'h1 << 23;
  localparam logic [31:0] M_IRIN  = 32'h1 << 22;
  localparam logic [31:0] M_MARIN = 32'h1 << 21;
  localparam logic [31:0] M_MDRIN = 32'h1 << 20;
  localparam logic [31:0] M_MDROUT= 32'h1 << 19;
  localparam logic [31:0] M_READ  = 32'h1 << 18;
  localparam logic [31:0] M_WRITE = 32'h1 << 17;
  localparam logic [31:0] M_YIN   = 32'h1 << 16;
  localparam logic [31:0] M_ZIN   = 32'h1 << 15;
  localparam logic [31:0] M_ZLOW  = 32'h1 << 14;
  localparam logic [31:0] M_COUT  = 32'h1 << 12;
  localparam logic [31:0] M_CONIN = 32'h1 << 7;
  localparam logic [31:0] M_INPRT = 32'h1 << 6;
  localparam logic [31:0] M_OUTPRT= 32'h1 << 5;
  localparam logic [31:0] M_RUN   = 32'h1;

  function automatic logic [31:0] alu(input logic [3:0] a);
    return {27'd0, a, 1'b0};
  endfunction

  function automatic logic [31:0] obs();
    return {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.PCout,
            bus.PCin, bus.IncPC, bus.IRin, bus.MARin, bus.MDRin, bus.MDRout,
            bus.Read, bus.Write, bus.Yin, bus.Zin, bus.ZLowout, bus.ZHighout,
            bus.Cout, bus.HIin, bus.LOin, bus.HIout, bus.LOout, bus.conIn,
            bus.InPortout, bus.outPortin, bus.ALUselect, bus.run};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected control words, one per cycle from T0, for one instruction
  task automatic model_instr(input logic [4:0] op, input bit con);
    logic [31:0] alu_sel;
    exp_q.delete();
    exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | alu(4'b1001) | M_RUN);
    exp_q.push_back(M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN);
    exp_q.push_back(M_MDROUT | M_IRIN | M_RUN);
    case (op)
      5'd0, 5'd1, 5'd2: begin
        exp_q.push_back(M_GRB | M_BAOUT | M_YIN | M_RUN);
        exp_q.push_back(M_COUT | M_ZIN | alu(4'b0001) | M_RUN);
        if (op == 5'd1) exp_q.push_back(M_ZLOW | M_GRA | M_RIN | M_RUN);
        else            exp_q.push_back(M_ZLOW | M_MARIN | M_RUN);
        if (op == 5'd0) begin
          exp_q.push_back(M_READ | M_MDRIN | M_RUN);
          exp_q.push_back(M_MDROUT | M_GRA | M_RIN | M_RUN);
        end else if (op == 5'd2) begin
          exp_q.push_back(M_GRA | M_ROUT | M_MDRIN | M_RUN);
          exp_q.push_back(M_MDROUT | M_WRITE | M_RUN);
        end
      end
      5'd3, 5'd4, 5'd5, 5'd6: begin
        alu_sel = (op == 5'd3) ? alu(4'b0001) : (op == 5'd4) ? alu(4'b0010) :
                  (op == 5'd5) ? alu(4'b0110) : alu(4'b0111);
        exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN);
        exp_q.push_back(M_GRC | M_ROUT | M_ZIN | alu_sel | M_RUN);
        exp_q.push_back(M_ZLOW | M_GRA | M_RIN | M_RUN);
      end
      5'd11, 5'd12, 5'd13: begin
        alu_sel = (op == 5'd11) ? alu(4'b0001) : (op == 5'd12) ? alu(4'b0110) : alu(4'b0111);
        exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN);
        exp_q.push_back(M_COUT | M_ZIN | alu_sel | M_RUN);
        exp_q.push_back(M_ZLOW | M_GRA | M_RIN | M_RUN);
      end
      5'd18: begin
        exp_q.push_back(M_GRA | M_ROUT | M_CONIN | M_RUN);
        exp_q.push_back(M_PCOUT | M_YIN | M_RUN);
        exp_q.push_back(M_COUT | M_ZIN | alu(4'b0001) | M_RUN);
        exp_q.push_back(con ? (M_ZLOW | M_PCIN | M_RUN) : M_RUN);
      end
      5'd21: exp_q.push_back(M_INPRT | M_GRA | M_RIN | M_RUN);
      5'd22: exp_q.push_back(M_GRA | M_ROUT | M_OUTPRT | M_RUN);
      default: ;
    endcase
  endtask

  // Reset pulse; the following negedge finds the sequencer in T0
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.stop = 1'b0;
    #1 check("reset_now", obs(), 32'h0);
    @(negedge clk);
    #1 check("reset_hold", obs(), 32'h0);
    reset = 1'b0;
  endtask

  task automatic check_halt(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.IR = $urandom;
      bus.stop = 1'($urandom);
      bus.CON_FF = 1'($urandom);
      #1 check("halt", obs(), 32'h0);
    end
  endtask

  // One instruction from T0; stop raised from step stop_from on, reset at abort_at
  task automatic run_instr(input logic [31:0] instr, input bit con, input int stop_from,
                           input int abort_at);
    logic [4:0] op;
    bit halted;
    op = instr[31:27];
    model_instr(op, con);
    halted = (op == 5'd26) || (stop_from >= 0 && stop_from < exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      bus.IR = (k == 2) ? instr : $urandom;
      bus.CON_FF = (k == 6) ? con : 1'($urandom);
      bus.stop = (stop_from >= 0 && k >= stop_from);
`ifdef CTRL_SINGLE_STEP_EN
      bus.step = 1'($urandom);
`endif
      if (k == abort_at) begin
        reset = 1'b1;
        #1 check("abort_now", obs(), 32'h0);
        @(negedge clk);
        bus.stop = 1'b0;
        #1 check("abort_hold", obs(), 32'h0);
        reset = 1'b0;
        return;
      end
      #1 check($sformatf("op%0d_T%0d", op, k), obs(), exp_q[k]);
    end
    if (halted) begin
      check_halt(20);
      do_reset();
      return;
    end
`ifdef CTRL_SINGLE_STEP_EN
    repeat (1 + $urandom_range(0, 2)) begin
      @(negedge clk);
      bus.step = 1'b0;
      bus.IR = $urandom;
      #1 check("hold", obs(), M_RUN);
    end
    @(negedge clk);
    bus.step = 1'b1;
    #1 check("hold_go", obs(), M_RUN);
`endif
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] instr;
    reset = 1'b1;
    bus.IR = 32'h0;
    bus.CON_FF = 1'b0;
    bus.stop = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    #12;
    do_reset();

    run_instr(32'h00800055, 1'b0, -1, -1);   // ld
    run_instr(32'h590FFFFB, 1'b1, -1, -1);   // addi
    run_instr(32'h1080005A, 1'b0, -1, -1);   // st
    run_instr(32'h91000023, 1'b1, -1, -1);   // br taken
    run_instr(32'h91000023, 1'b0, -1, -1);   // br not taken
    run_instr(32'h00800055, 1'b0, -1, 5);    // reset in T5 of ld
    run_instr(32'hA8000000, 1'b0, -1, -1);   // in
    run_instr(32'hC8000000, 1'b0, -1, -1);   // nop
    run_instr(32'h38000000, 1'b0, -1, -1);   // unlisted opcode 7
    run_instr(32'h08800055, 1'b0, 4, -1);    // ldi with stop in T4
    run_instr(32'hD0000000, 1'b0, -1, -1);   // halt opcode

    for (int i = 0; i < 120; i++) begin
      op = 5'($urandom_range(0, 31));
      instr = {op, 27'($urandom)};
      run_instr(instr, 1'($urandom),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1,
                ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
